// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
// The RD_STREAM_LAST_EN build option is consumed by fifo_rd_stream.sv.
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;

    // Counter width for a modulo-n counter; a 1-beat burst still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_beat.sv
// Modulo-BURST_LEN beat counter used for m_last framing.
// Advances on every accepted beat and wraps after BURST_LEN-1.
module burst_beat_counter
    import fifo_rd_stream_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    output logic at_last_o
);

    localparam int              CW   = cnt_width(BURST_LEN);
    localparam logic [CW-1:0]   LAST = CW'(BURST_LEN - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last_o = (count_q == LAST);

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port (async-read data) into a valid/ready stream via a 2-entry skid buffer.
// Define RD_STREAM_LAST_EN to add the m_last port and burst beat counter.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef RD_STREAM_LAST_EN
    ,
    output logic                  m_last
`endif
);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("fifo_rd_stream: BURST_LEN must be within 1..256");
    end

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  push;
    logic                  pop;

    // Popping only while a slot is free keeps the buffer from ever overflowing.
    assign r_en    = !r_empty && (state_q != TWO) && !r_rst;
    assign push    = r_en;
    assign m_valid = (state_q != EMPTY);
    assign pop     = m_valid && m_ready;
    assign m_data  = head_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = r_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = r_data;
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = r_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef RD_STREAM_LAST_EN
    logic at_last;

    burst_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_cnt (
        .clk_i     (r_clk),
        .rst_i     (r_rst),
        .inc_i     (pop),
        .at_last_o (at_last)
    );

    assign m_last = m_valid && at_last;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: queue-based model of source FIFO and 2-deep output buffer, checked every cycle.
// Honours RD_STREAM_LAST_EN for the m_last checks.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          r_clk   = 1'b0;
    logic          r_rst   = 1'b1;
    logic          r_empty = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] r_data  = '0;
    logic          r_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
`ifdef RD_STREAM_LAST_EN
    logic          m_last;
`endif

    always #5 r_clk = ~r_clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .r_clk   (r_clk),
        .r_rst   (r_rst),
        .r_empty (r_empty),
        .r_data  (r_data),
        .r_en    (r_en),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef RD_STREAM_LAST_EN
        ,
        .m_last  (m_last)
`endif
    );

    // Source FIFO contents and the model of words held by the adapter.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] mdl_q[$];
    int            mdl_beats = 0;
    bit            mdl_known = 1'b0;

    // Log of accepted beats and pop cycles, used for the hand-computed checks.
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    bit            got_last[$];
    int            ren_cyc[$];
    int            cyc = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        got_last.delete();
        ren_cyc.delete();
    endtask

    // One clock: drive inputs on the falling edge, compare, then advance the model.
    task automatic cycle(input logic rst, input logic rdy);
        logic exp_ren;
        bit   do_pop;
        @(negedge r_clk);
        r_rst   = rst;
        m_ready = rdy;
        r_empty = (src_q.size() == 0);
        r_data  = r_empty ? '0 : src_q[0];
        #1;
        exp_ren = !r_empty && (mdl_q.size() < 2) && !rst;
        check("r_en", 32'(r_en), 32'(exp_ren));
        if (mdl_known) begin
            check("m_valid", 32'(m_valid), 32'(mdl_q.size() != 0));
            if (mdl_q.size() != 0) begin
                check("m_data", 32'(m_data), 32'(mdl_q[0]));
            end
`ifdef RD_STREAM_LAST_EN
            check("m_last", 32'(m_last),
                  32'((mdl_q.size() != 0) && ((mdl_beats % BL) == BL - 1)));
`endif
        end
        if (r_en === 1'b1) ren_cyc.push_back(cyc);
        if (m_valid === 1'b1 && rdy) begin
            got_q.push_back(m_data);
            got_cyc.push_back(cyc);
`ifdef RD_STREAM_LAST_EN
            got_last.push_back(m_last === 1'b1);
`else
            got_last.push_back(1'b0);
`endif
        end
        if (rst) begin
            mdl_q.delete();
            mdl_beats = 0;
            mdl_known = 1'b1;
        end else begin
            do_pop = (mdl_q.size() != 0) && rdy;
            if (do_pop) begin
                void'(mdl_q.pop_front());
                mdl_beats++;
            end
            if (exp_ren) mdl_q.push_back(src_q.pop_front());
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, rdy);
    endtask

    initial begin
        // Reset with a non-empty source: nothing may be popped or presented.
        for (int i = 0; i < 8; i++) src_q.push_back(8'h11 + 8'(i));
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("rst_r_en", 32'(r_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);

        // Full-rate streaming of 0x11..0x18.
        clear_logs();
        run(12, 1'b1);
        check("stream_pops", ren_cyc.size(), 32'd8);
        check("stream_beats", got_q.size(), 32'd8);
        if (got_q.size() == 8 && ren_cyc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("stream_data", 32'(got_q[i]), 32'h11 + 32'(i));
                check("stream_cycle", got_cyc[i], ren_cyc[0] + 1 + i);
                check("stream_ren_cycle", ren_cyc[i], ren_cyc[0] + i);
            end
        end

        // Backpressure: two pops fill the buffer, head holds at 0xA0.
        clear_logs();
        for (int i = 0; i < 4; i++) src_q.push_back(8'hA0 + 8'(i));
        run(4, 1'b0);
        check("bp_pops", ren_cyc.size(), 32'd2);
        check("bp_src_left", src_q.size(), 32'd2);
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        check("bp_hold_data", 32'(m_data), 32'hA0);
        check("bp_full_ren", 32'(r_en), 32'd0);
        run(8, 1'b1);
        check("bp_beats", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("bp_data", 32'(got_q[i]), 32'hA0 + 32'(i));
        end

        // Single word then empty.
        clear_logs();
        src_q.push_back(8'h5C);
        run(4, 1'b1);
        check("single_pops", ren_cyc.size(), 32'd1);
        check("single_beats", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("single_data", 32'(got_q[0]), 32'h5C);
        check("single_idle_valid", 32'(m_valid), 32'd0);
        check("single_idle_ren", 32'(r_en), 32'd0);

        // Burst framing over 10 beats, then 2 more to reach the third burst end.
        cycle(1'b1, 1'b1);
        clear_logs();
        for (int i = 0; i < 10; i++) src_q.push_back(8'h30 + 8'(i));
        run(14, 1'b1);
        check("frame_beats", got_q.size(), 32'd10);
        check("frame_model_cnt", mdl_beats % BL, 32'd2);
`ifdef RD_STREAM_LAST_EN
        if (got_last.size() == 10) begin
            for (int i = 0; i < 10; i++)
                check("frame_last", 32'(got_last[i]), 32'(i == 3 || i == 7));
        end
`endif
        src_q.push_back(8'h3A);
        src_q.push_back(8'h3B);
        run(4, 1'b1);
        check("frame_beats12", got_q.size(), 32'd12);
`ifdef RD_STREAM_LAST_EN
        if (got_last.size() == 12) begin
            check("frame_last11", 32'(got_last[10]), 32'd0);
            check("frame_last12", 32'(got_last[11]), 32'd1);
        end
`endif

        // Reset while the buffer is full: buffered words are dropped.
        clear_logs();
        for (int i = 0; i < 5; i++) src_q.push_back(8'h61 + 8'(i));
        run(3, 1'b0);
        check("mid_full_valid", 32'(m_valid), 32'd1);
        check("mid_full_ren", 32'(r_en), 32'd0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        clear_logs();
        run(6, 1'b1);
        check("mid_beats", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            for (int i = 0; i < 3; i++) check("mid_data", 32'(got_q[i]), 32'h63 + 32'(i));
        end
`ifdef RD_STREAM_LAST_EN
        if (got_last.size() == 3) check("mid_no_last", 32'(got_last[2]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, width of FIFO read data and stream data.
REQ-002 SHALL have parameter BURST_LEN, 4, number of beats per burst for m_last framing; legal range is 1 to 256.
REQ-003 SHALL have one clock and one reset, with reset synchronous and active-high: r_clk  input  1  read-domain clock.
REQ-004 SHALL have r_rst  input  1  synchronous active-high reset.
REQ-005 SHALL have r_empty  input  1  FIFO read-side empty flag.
REQ-006 SHALL have r_data  input  DATA_WIDTH  FIFO read data, valid in the same cycle as address (asynchronous memory read).
REQ-007 SHALL have r_en  output  1  FIFO read enable (pop).
REQ-008 SHALL have m_valid  output  1  stream data valid.
REQ-009 SHALL have m_ready  input  1  downstream ready.
REQ-010 SHALL have m_data  output  DATA_WIDTH  stream data (head of buffer).
REQ-011 SHALL have m_last  output  1  final beat of burst (present only with RD_STREAM_LAST_EN).

Function
REQ-012 SHALL hold a 2-entry FIFO-ordered output buffer tracked by state machine EMPTY/ONE/TWO (occupancy 0/1/2).
REQ-013 SHALL drive r_en combinationally = !r_empty && state!=TWO && !r_rst.
REQ-014 SHALL define push = r_en and pop = m_valid && m_ready; push captures r_data at that r_clk edge.
REQ-015 SHALL transition EMPTY->ONE on push; ONE->TWO on push&!pop; ONE->EMPTY on pop&!push; ONE->ONE on push&pop or idle; TWO->ONE on pop; otherwise hold.
REQ-016 SHALL assert m_valid = (state!=EMPTY); first word appears on m_data exactly 1 cycle after the push edge.
REQ-017 SHALL sustain 1 word/cycle when r_empty=0 and m_ready=1 continuously.
REQ-018 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-019 SHALL preserve FIFO order; no word dropped or duplicated outside reset.
REQ-020 SHALL ignore m_ready when m_valid=0; m_valid SHALL NOT depend combinationally on m_ready.
REQ-021 SHALL on simultaneous push and pop in TWO be impossible (r_en=0 in TWO); in ONE the popped word is the old head and the pushed word becomes the new head.

Reset
REQ-022 SHALL on r_rst=1 at an r_clk edge set state=EMPTY, m_valid=0, m_data=0, beat counter=0, m_last=0; r_en SHALL be 0 while r_rst=1.
REQ-023 SHALL discard buffered words on reset mid-operation; words already popped from the FIFO are lost by design.

Configuration
REQ-024 SHALL use macro RD_STREAM_LAST_EN: when defined, port m_last and a beat counter (0..BURST_LEN-1, increments on pop, wraps to 0 after BURST_LEN-1) exist, and m_last = m_valid && count==BURST_LEN-1.
REQ-025 SHALL when RD_STREAM_LAST_EN is undefined omit m_last port and counter; all other behaviour identical.
REQ-026 SHALL with BURST_LEN=1 assert m_last on every valid beat.

Structure
REQ-027 SHALL place the state typedef (EMPTY/ONE/TWO) and default parameter constants in shared package fifo_rd_stream_pkg.
REQ-028 SHALL implement the beat counter as sub-module burst_beat_counter, instantiated only under RD_STREAM_LAST_EN.

Verification
REQ-029 Reset: r_rst=1 for 2 cycles with r_empty=0 -> r_en=0, m_valid=0, m_data=0 throughout.
REQ-030 Streaming: FIFO holds 0x11..0x18, m_ready=1 -> r_en high 8 cycles, m_data 0x11..0x18 on 8 consecutive cycles, first one cycle after first r_en.
REQ-031 Backpressure: m_ready=0 with FIFO holding 0xA0..0xA3 -> exactly 2 pops, state TWO, m_data=0xA0 held; release m_ready -> 0xA0,0xA1,0xA2,0xA3 in order, no loss.
REQ-032 Empty boundary: single word 0x5C then r_empty=1 -> one pop, m_valid for one beat with m_ready=1, then m_valid=0 and r_en=0.
REQ-033 Framing (RD_STREAM_LAST_EN, BURST_LEN=4): 10 beats -> m_last on beats 4 and 8 only; counter=2 after beat 10.
REQ-034 Reset mid-operation: assert r_rst while state TWO -> next cycle m_valid=0, state EMPTY, counter=0; after release next FIFO word is the next head.
